// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg: shared constants and state type for the fetch front end.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int          DEFAULT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// +----------------------------------------------------------------------+
// | fetch_unit_if: instruction-memory and decode handshake bundle.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if #(
  parameter int XLEN = fetch_pkg::DEFAULT_XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit_mux21.sv
// +----------------------------------------------------------------------+
// | mux21: N-bit 2:1 multiplexer, y = s ? b : a.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mux21 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? b : a;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | fetch_unit: PC owner, single-outstanding imem fetch, 1-entry output.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;

  logic            w_req_valid;
  logic            w_accept;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_pc_mux;

  // Only request when the output slot is empty or drains this cycle.
  assign w_req_valid = !rst && (state_q == IDLE) && !redirect &&
                       (!if_valid_q || bus.if_ready);
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  assign w_pc_inc    = pc_q + XLEN'(PC_STEP);
  assign w_redir_pc  = redirect_pc & ~XLEN'(3);

  mux21 #(.N(XLEN)) u_pc_mux (
    .a (w_pc_inc),
    .b (w_redir_pc),
    .s (redirect),
    .y (w_pc_mux)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (w_accept || redirect) pc_d = w_pc_mux;
    if (w_accept)             req_pc_d = pc_q;

    case (state_q)
      IDLE: if (w_accept) state_d = WAIT;
      WAIT: begin
        if (redirect)                state_d = bus.imem_rsp_valid ? IDLE : KILL;
        else if (bus.imem_rsp_valid) state_d = IDLE;
      end
      KILL:    if (bus.imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      if_valid_d = 1'b0;
    end else if ((state_q == WAIT) && bus.imem_rsp_valid) begin
      if_valid_d = 1'b1;
      if_pc_d    = req_pc_q;
      if_instr_d = bus.imem_rsp_data;
    end else if (if_valid_q && bus.if_ready) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= XLEN'(NOP_INSTR);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that owns the program counter and produces the PC/instruction pair for decode.
- Next-PC selection (pc+4 vs. redirect target) goes through the existing 2:1 mux (mux21) feeding the PC register.
- Issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the response in a one-entry output register handed to decode via valid/ready.
- Squashes in-flight fetches on a redirect from branch/jump resolution.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (= current PC)
imem_rsp_valid  input  1  instruction returned
imem_rsp_data  input  XLEN  instruction word
if_valid  output  1  output register holds a valid instruction
if_ready  input  1  decode consumes output this cycle
if_pc  output  XLEN  PC of held instruction
if_instr  output  XLEN  held instruction

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, state = IDLE, if_valid = 0, if_pc = 0, if_instr = NOP (32'h0000_0013).
  - imem_req_valid = 0 while rst is high.
- State machine (fetch_state_t):
  - IDLE: no request outstanding.
  - WAIT: request accepted, response pending.
  - KILL: request outstanding but squashed; its response is discarded.
- imem_req_valid (combinational) = (state==IDLE) & !redirect & (!if_valid | if_ready).
  - Room is guaranteed: the held instruction is empty or leaves this cycle.
- imem_req_addr = pc.
- Valid/ready handshake rules:
  - Request is held stable until accepted.
  - imem_req_valid never drops without acceptance, except on redirect.
- Request accepted (valid & ready): req_pc <= pc; pc <= pc+4 (via mux21, s=0); state -> WAIT.
- PC arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Response timing: a response is never accepted in the same cycle as its request; the earliest is the next cycle.
- WAIT with imem_rsp_valid:
  - if_pc <= req_pc, if_instr <= imem_rsp_data, if_valid <= 1.
  - state -> IDLE.
  - Fetch-to-if_valid latency is 1 cycle after response, 2 cycles minimum after request acceptance.
- Output register:
  - if_valid & if_ready with no new response: if_valid <= 0.
  - Data is held stable while if_valid & !if_ready.
- Redirect (highest priority):
  - pc <= {redirect_pc[XLEN-1:2],2'b00} via mux21 s=1; if_valid <= 0; no request issued that cycle.
  - In WAIT: rsp_valid in the same cycle -> response dropped, IDLE; otherwise -> KILL.
  - In KILL: remains KILL until the response arrives.
  - In IDLE: remains IDLE.
- KILL with imem_rsp_valid: data discarded, state -> IDLE; the next request uses the redirected pc.
- imem_rsp_valid in IDLE is a protocol error; it is ignored.
- Reset mid-fetch: everything returns to reset values.
  - Memory is reset together with fetch_unit; no response is expected afterwards.

Decomposition:
- Package fetch_pkg holds:
  - XLEN default
  - NOP_INSTR = 32'h0000_0013
  - PC_STEP = 4
  - typedef enum logic [1:0] fetch_state_t {IDLE, WAIT, KILL}
- Sub-module: the existing mux21 (N=XLEN) instantiated once for next-PC select.
  - a = pc+4, b = aligned redirect_pc, s = redirect.
  - PC register loads the mux21 output on request acceptance or redirect.

Test Plan:
- Reset release, RESET_PC=0, imem ready always, 1-cycle response returning 0xA0+addr, if_ready=1 -> if_pc sequence 0,4,8,… with if_instr 0xA0,0xA4,0xA8; one instruction every 2 cycles.
- Decode backpressure: if_ready=0 for 5 cycles with if_valid=1 -> if_pc/if_instr stable, imem_req_valid=0; release -> next fetch addr = held pc+4.
- Redirect while WAIT to 32'h0000_0102 -> late response for old PC discarded (never on if_valid); next imem_req_addr = 32'h0000_0100.
- Redirect in the same cycle as imem_rsp_valid -> response dropped, if_valid=0, state IDLE, next request at redirect target.
- Wrap: redirect to 32'hFFFF_FFFC -> fetched if_pc=32'hFFFF_FFFC, next imem_req_addr=32'h0000_0000.
- Async rst asserted mid-WAIT, between clock edges -> if_valid=0, imem_req_valid=0, if_instr=NOP immediately; after release first request at RESET_PC.
